// File: rtl/seq_divider.sv
// ============================================================================
// Module   : seq_divider
// Purpose  : Multicycle signed restoring divider, one quotient bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             ready,
    output logic             div_by_zero
);

    localparam int             CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]  c_last = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvsr;
    logic             r_neg_q;
    logic             r_neg_r;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_dvsr_n;
    logic [WIDTH:0]   w_trial;
    logic             w_start_ok;

    assign w_dvd_mag  = dividend[WIDTH-1] ? (~dividend + c_one) : dividend;
    assign w_dvs_mag  = divisor[WIDTH-1]  ? (~divisor  + c_one) : divisor;
    assign w_start_ok = start && (divisor != '0);
    assign busy       = (r_state != IDLE);

    // The kept remainder is always below the divisor, so its bit WIDTH is
    // always zero and is not stored; the WIDTH+1-bit view exists only here.
    assign w_shift  = {r_rem, r_quo[WIDTH-1]};
    assign w_dvsr_n = ~{1'b0, r_dvsr};

    always_comb begin : p_ripple_sub
        logic carry;
        carry   = 1'b1;
        w_trial = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            w_trial[i] = w_shift[i] ^ w_dvsr_n[i] ^ carry;
            carry      = (w_shift[i] & w_dvsr_n[i]) | (carry & (w_shift[i] ^ w_dvsr_n[i]));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_next = RUN;
            RUN:     if (r_cnt == c_last) w_next = FIX;
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt       <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_dvsr      <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            ready       <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '0;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                            ready       <= 1'b1;
                        end else begin
                            r_neg_q     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            r_neg_r     <= dividend[WIDTH-1];
                            r_quo       <= w_dvd_mag;
                            r_dvsr      <= w_dvs_mag;
                            r_rem       <= '0;
                            r_cnt       <= '0;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    // A clear trial sign bit means the subtraction fits.
                    r_rem <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: begin
                    quotient  <= r_neg_q ? (~r_quo + c_one) : r_quo;
                    remainder <= r_neg_r ? (~r_rem + c_one) : r_rem;
                    ready     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// Module   : tb_seq_divider
// Purpose  : Randomized and directed self-checking bench for seq_divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         ready;
    logic         div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_z;

    always #5 clock = ~clock;

    seq_divider #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .ready       (ready),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Signed division with truncation toward zero, results wrapped to W bits.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            q = '0; r = '0; z = 1'b1;
        end else begin
            q = W'(sa / sb); r = W'(sa % sb); z = 1'b0;
        end
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int glitch);
        int           lat;
        int           busy_n;
        bit           held;
        logic [W-1:0] prev_q;
        logic [W-1:0] prev_r;
        model(a, b, exp_q, exp_r, exp_z);
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        if (b == '0) begin
            check("dz_ready", ready, 1);
            check("dz_flag", div_by_zero, 1);
            check("dz_busy", busy, 0);
            check("dz_quo", quotient, 0);
            check("dz_rem", remainder, 0);
        end else begin
            check("ready_low_at_start", ready, 0);
            prev_q = quotient;
            prev_r = remainder;
            held   = 1'b1;
            lat    = 0;
            busy_n = 0;
            while (!ready && lat < 100) begin
                if (busy) busy_n++;
                if (quotient !== prev_q || remainder !== prev_r) held = 1'b0;
                if (lat == glitch) begin
                    dividend = ~a;
                    divisor  = b + 3;
                    start    = 1'b1;
                end else begin
                    start = 1'b0;
                end
                @(posedge clock);
                #1;
                lat++;
            end
            start = 1'b0;
            check("latency", lat, W + 1);
            check("busy_cycles", busy_n, W + 1);
            check("outputs_held_in_flight", held, 1);
            check("quotient", quotient, exp_q);
            check("remainder", remainder, exp_r);
            check("dz_clear", div_by_zero, 0);
            check("busy_low_at_ready", busy, 0);
        end
    endtask

    task automatic idle_check();
        @(posedge clock);
        #1;
        check("ready_one_cycle", ready, 0);
        check("hold_quotient", quotient, exp_q);
        check("hold_remainder", remainder, exp_r);
        check("hold_dz", div_by_zero, exp_z);
        check("idle_busy", busy, 0);
    endtask

    logic [W-1:0] dir_a [9] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C, 32'd5,
                                32'd9, 32'h8000_0000, 32'h7FFF_FFFF, 32'd3};
    logic [W-1:0] dir_b [9] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd0,
                                32'd3, 32'hFFFF_FFFF, 32'd1, 32'd10};

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           seen;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 0);
        check("rst_dz", div_by_zero, 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_op(dir_a[i], dir_b[i], -1);
            idle_check();
        end

        // Re-pulsed start mid-operation, then a start in the ready cycle.
        do_op(32'd100, 32'd7, 10);
        do_op(32'd1000, 32'hFFFF_FFF7, -1);
        idle_check();

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = -W'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            do_op(ra, rb, -1);
            if ($urandom_range(0, 1) == 1) idle_check();
        end

        // Abort with reset at cycle 15 of an operation.
        @(negedge clock);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dz", div_by_zero, 0);
        @(negedge clock);
        reset = 1'b0;
        seen  = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (ready) seen++;
        end
        check("no_ready_after_abort", seen, 0);
        do_op(32'd100, 32'd7, -1);
        idle_check();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
